// File: rtl/alu_pkg.sv
// Shared op encodings, FSM states and op-category decode for the multi-cycle ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_NAND = 4'b0110;
  localparam logic [3:0] OP_NOR  = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_XNOR = 4'b1001;
  localparam logic [3:0] OP_EQ   = 4'b1010;
  localparam logic [3:0] OP_GT   = 4'b1011;
  localparam logic [3:0] OP_LT   = 4'b1100;
  localparam logic [3:0] OP_SHR  = 4'b1101;
  localparam logic [3:0] OP_SHL  = 4'b1110;
  localparam logic [3:0] OP_NOP  = 4'b1111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DIV  = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    CL_ARITH,
    CL_LOGIC,
    CL_CMP,
    CL_SHIFT,
    CL_NONE
  } op_class_t;

  function automatic op_class_t op_class(input logic [3:0] op);
    if (op <= OP_DIV)       return CL_ARITH;
    else if (op <= OP_XNOR) return CL_LOGIC;
    else if (op <= OP_LT)   return CL_CMP;
    else if (op <= OP_SHL)  return CL_SHIFT;
    else                    return CL_NONE;
  endfunction

endpackage

// File: rtl/alu_mc_seq_if.sv
// Operand/op input handshake and result/flag outputs of the multi-cycle ALU.
interface alu_mc_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       ALU_FUN;
  logic             out_valid;
  logic [WIDTH-1:0] ALU_OUT;
  logic             Carry_Flag;
  logic             Arith_Flag;
  logic             Logic_Flag;
  logic             CMP_Flag;
  logic             Shift_Flag;
  logic             Ovf_Flag;
  logic             Div0_Flag;

  modport master (
    output in_valid, A, B, ALU_FUN,
    input  in_ready, out_valid, ALU_OUT, Carry_Flag, Arith_Flag, Logic_Flag,
           CMP_Flag, Shift_Flag, Ovf_Flag, Div0_Flag
  );

  modport slave (
    input  in_valid, A, B, ALU_FUN,
    output in_ready, out_valid, ALU_OUT, Carry_Flag, Arith_Flag, Logic_Flag,
           CMP_Flag, Shift_Flag, Ovf_Flag, Div0_Flag
  );
endinterface

// File: rtl/alu_div_seq.sv
// Iterative restoring divider: one quotient bit per cycle, WIDTH steps after start.
module alu_div_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);

  logic             busy;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;

  // quo doubles as the dividend shift register; quotient bits enter at the LSB
  always_comb begin
    rem_sh = {rem, quo[WIDTH-1]};
    diff   = rem_sh - {1'b0, dsr};
    if (diff[WIDTH]) begin
      rem_nx = rem_sh[WIDTH-1:0];
      quo_nx = {quo[WIDTH-2:0], 1'b0};
    end else begin
      rem_nx = diff[WIDTH-1:0];
      quo_nx = {quo[WIDTH-2:0], 1'b1};
    end
  end

  // Final quotient is presented on the step edge itself so the caller can capture it there
  assign done     = busy && (cnt == CNT_W'(1));
  assign quotient = quo_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      cnt  <= '0;
      rem  <= '0;
      quo  <= '0;
      dsr  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= CNT_W'(WIDTH);
      rem  <= '0;
      quo  <= dividend;
      dsr  <= divisor;
    end else if (busy) begin
      rem <= rem_nx;
      quo <= quo_nx;
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc_seq.sv
// Multi-cycle ALU: single-cycle ops registered on accept, divide via iterative divider.
module alu_mc_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_mc_seq_if.slave  bus
);

  state_t           state;
  state_t           state_nx;
  op_class_t        cls;
  logic             accept;
  logic             div_start;
  logic             load_now;
  logic             div_done;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic             ovf;
  logic             div0;
  logic [WIDTH:0]   sum;
  logic [2*WIDTH-1:0] prod;

  alu_div_seq #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (bus.A),
    .divisor  (bus.B),
    .done     (div_done),
    .quotient (div_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (div_start) state_nx = ST_DIV;
      ST_DIV:  if (div_done)  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // in_ready is gated by rst_n so it reads 0 throughout reset, not just after it
  always_comb begin
    bus.in_ready = rst_n && (state == ST_IDLE);
    accept       = bus.in_valid && bus.in_ready;
    div_start    = accept && (bus.ALU_FUN == OP_DIV) && (bus.B != '0);
    load_now     = accept && !div_start;
  end

  always_comb begin
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    div0  = 1'b0;
    cls   = op_class(bus.ALU_FUN);
    sum   = {1'b0, bus.A} + {1'b0, bus.B};
    prod  = {{WIDTH{1'b0}}, bus.A} * {{WIDTH{1'b0}}, bus.B};
    case (bus.ALU_FUN)
      OP_ADD:  begin res = sum[WIDTH-1:0]; carry = sum[WIDTH]; end
      OP_SUB:  begin res = bus.A - bus.B; carry = (bus.A < bus.B); end
      OP_MUL:  begin res = prod[WIDTH-1:0]; ovf = |prod[2*WIDTH-1:WIDTH]; end
      OP_DIV:  begin res = '1; div0 = 1'b1; end
      OP_AND:  res = bus.A & bus.B;
      OP_OR:   res = bus.A | bus.B;
      OP_NAND: res = ~(bus.A & bus.B);
      OP_NOR:  res = ~(bus.A | bus.B);
      OP_XOR:  res = bus.A ^ bus.B;
      OP_XNOR: res = ~(bus.A ^ bus.B);
      OP_EQ:   res = (bus.A == bus.B) ? WIDTH'(1) : '0;
      OP_GT:   res = (bus.A > bus.B)  ? WIDTH'(2) : '0;
      OP_LT:   res = (bus.A < bus.B)  ? WIDTH'(3) : '0;
      OP_SHR:  res = bus.A >> 1;
      OP_SHL:  res = bus.A << 1;
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid  <= 1'b0;
      bus.ALU_OUT    <= '0;
      bus.Carry_Flag <= 1'b0;
      bus.Arith_Flag <= 1'b0;
      bus.Logic_Flag <= 1'b0;
      bus.CMP_Flag   <= 1'b0;
      bus.Shift_Flag <= 1'b0;
      bus.Ovf_Flag   <= 1'b0;
      bus.Div0_Flag  <= 1'b0;
    end else begin
      bus.out_valid <= load_now || div_done;
      if (div_done) begin
        bus.ALU_OUT    <= div_q;
        bus.Carry_Flag <= 1'b0;
        bus.Arith_Flag <= 1'b1;
        bus.Logic_Flag <= 1'b0;
        bus.CMP_Flag   <= 1'b0;
        bus.Shift_Flag <= 1'b0;
        bus.Ovf_Flag   <= 1'b0;
        bus.Div0_Flag  <= 1'b0;
      end else if (load_now) begin
        bus.ALU_OUT    <= res;
        bus.Carry_Flag <= carry;
        bus.Arith_Flag <= (cls == CL_ARITH);
        bus.Logic_Flag <= (cls == CL_LOGIC);
        bus.CMP_Flag   <= (cls == CL_CMP);
        bus.Shift_Flag <= (cls == CL_SHIFT);
        bus.Ovf_Flag   <= ovf;
        bus.Div0_Flag  <= div0;
      end
    end
  end

endmodule

// File: tb/tb_alu_mc_seq.sv
// Bench for alu_mc_seq at WIDTH=16 and WIDTH=8 against a plain-arithmetic reference model.
module tb_alu_mc_seq;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_mc_seq_if #(.WIDTH(16)) b16 ();
  alu_mc_seq_if #(.WIDTH(8))  b8 ();

  alu_mc_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));
  alu_mc_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [63:0] res;
    logic [6:0]  flg;
    int          lat;
  } exp_t;

  // flags packed as {Carry, Arith, Logic, CMP, Shift, Ovf, Div0}
  function automatic exp_t model(input int w, input logic [3:0] op,
                                 input longint unsigned a, input longint unsigned b);
    exp_t e;
    longint unsigned m = (64'd1 << w) - 64'd1;
    longint unsigned r = 0;
    logic c = 0, ar = 0, lg = 0, cm = 0, sh = 0, ov = 0, dz = 0;
    e.lat = 1;
    if (op <= 3) ar = 1;
    else if (op <= 9) lg = 1;
    else if (op <= 12) cm = 1;
    else if (op <= 14) sh = 1;
    case (op)
      4'd0:  begin r = (a + b) & m; c = ((a + b) >> w) != 0; end
      4'd1:  begin r = (a - b) & m; c = a < b; end
      4'd2:  begin r = (a * b) & m; ov = ((a * b) >> w) != 0; end
      4'd3:  if (b == 0) begin r = m; dz = 1; end
             else begin r = a / b; e.lat = w + 1; end
      4'd4:  r = a & b;
      4'd5:  r = a | b;
      4'd6:  r = ~(a & b) & m;
      4'd7:  r = ~(a | b) & m;
      4'd8:  r = a ^ b;
      4'd9:  r = ~(a ^ b) & m;
      4'd10: r = (a == b) ? 1 : 0;
      4'd11: r = (a > b) ? 2 : 0;
      4'd12: r = (a < b) ? 3 : 0;
      4'd13: r = a >> 1;
      4'd14: r = (a << 1) & m;
      default: r = 0;
    endcase
    e.res = r;
    e.flg = {c, ar, lg, cm, sh, ov, dz};
    return e;
  endfunction

  function automatic logic [63:0] o_res(input bit w8);
    return w8 ? 64'(b8.ALU_OUT) : 64'(b16.ALU_OUT);
  endfunction
  function automatic logic [6:0] o_flg(input bit w8);
    return w8 ? {b8.Carry_Flag, b8.Arith_Flag, b8.Logic_Flag, b8.CMP_Flag, b8.Shift_Flag, b8.Ovf_Flag, b8.Div0_Flag}
              : {b16.Carry_Flag, b16.Arith_Flag, b16.Logic_Flag, b16.CMP_Flag, b16.Shift_Flag, b16.Ovf_Flag, b16.Div0_Flag};
  endfunction
  function automatic logic o_val(input bit w8);
    return w8 ? b8.out_valid : b16.out_valid;
  endfunction
  function automatic logic o_rdy(input bit w8);
    return w8 ? b8.in_ready : b16.in_ready;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit w8, input logic v, input logic [3:0] op,
                       input logic [63:0] a, input logic [63:0] b);
    if (w8) begin
      b8.in_valid = v; b8.ALU_FUN = op; b8.A = a[7:0]; b8.B = b[7:0];
    end else begin
      b16.in_valid = v; b16.ALU_FUN = op; b16.A = a[15:0]; b16.B = b[15:0];
    end
  endtask

  task automatic run(input bit w8, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    int edges = 0;
    int lowc = 0;
    bit seen = 0;
    e = model(w8 ? 8 : 16, op, a, b);
    @(negedge clk);
    drive(w8, 1'b1, op, a, b);
    chk("ready_at_issue", 64'(o_rdy(w8)), 64'd1);
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    drive(w8, 1'b0, op, a, b);
    for (int k = 0; k < 80; k++) begin
      if (o_val(w8)) begin seen = 1; break; end
      if (!o_rdy(w8)) lowc++;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    chk("out_valid_seen", 64'(seen), 64'd1);
    chk("latency", 64'(edges), 64'(e.lat));
    chk("ready_low_cycles", 64'(lowc), 64'(e.lat - 1));
    chk("result", o_res(w8), e.res);
    chk("flags", 64'(o_flg(w8)), 64'(e.flg));
    @(negedge clk);
    chk("pulse_one_cycle", 64'(o_val(w8)), 64'd0);
    chk("result_hold", o_res(w8), e.res);
  endtask

  logic [3:0]  bb_op [4];
  logic [63:0] bb_a  [4];
  logic [63:0] bb_b  [4];

  initial begin
    exp_t e;
    int edges;
    int lowc;
    int stale;
    bit w8;
    logic [3:0] op;
    logic [63:0] a, b, m;

    drive(1'b0, 1'b0, OP_NOP, 0, 0);
    drive(1'b1, 1'b0, OP_NOP, 0, 0);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst16_outputs", {b16.in_ready, b16.out_valid, 64'(b16.ALU_OUT), 57'(o_flg(0))}, '0);
    chk("rst8_outputs",  {b8.in_ready, b8.out_valid, 64'(b8.ALU_OUT), 57'(o_flg(1))}, '0);
    rst_n = 1'b1;
    #1;
    chk("rst16_ready_after_release", 64'(b16.in_ready), 64'd1);

    // Directed arithmetic cases
    run(0, OP_ADD, 64'hFFFF, 64'h0001);
    run(0, OP_SUB, 64'h0003, 64'h0005);
    run(0, OP_MUL, 64'h0100, 64'h0100);
    run(0, OP_DIV, 64'h1234, 64'h0000);

    // Divide with a second op held on in_valid throughout
    @(negedge clk);
    drive(0, 1'b1, OP_DIV, 100, 7);
    @(posedge clk);
    edges = 1;
    lowc = 0;
    @(negedge clk);
    drive(0, 1'b1, OP_ADD, 2, 3);
    for (int k = 0; k < 40; k++) begin
      if (b16.out_valid) break;
      if (!b16.in_ready) lowc++;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    chk("div_held_latency", 64'(edges), 64'd17);
    chk("div_held_ready_low", 64'(lowc), 64'd16);
    chk("div_held_quotient", 64'(b16.ALU_OUT), 64'd14);
    chk("div_held_flags", 64'(o_flg(0)), 64'b0100000);
    @(negedge clk);
    drive(0, 1'b0, OP_ADD, 2, 3);
    chk("held_op_valid", 64'(b16.out_valid), 64'd1);
    chk("held_op_result", 64'(b16.ALU_OUT), 64'd5);
    @(negedge clk);
    chk("held_op_single", 64'(b16.out_valid), 64'd0);

    // Reset in the middle of a divide
    drive(0, 1'b1, OP_DIV, 100, 7);
    @(posedge clk);
    #1 drive(0, 1'b0, OP_NOP, 0, 0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {b16.in_ready, b16.out_valid, 64'(b16.ALU_OUT), 57'(o_flg(0))}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_ready", 64'(b16.in_ready), 64'd1);
    stale = 0;
    repeat (25) begin
      @(negedge clk);
      if (b16.out_valid) stale++;
    end
    chk("midrst_no_stale_valid", 64'(stale), 64'd0);

    // Back-to-back single-cycle ops
    bb_op[0] = OP_AND; bb_a[0] = 64'hF0F0; bb_b[0] = 64'h3C3C;
    bb_op[1] = OP_GT;  bb_a[1] = 64'd9;    bb_b[1] = 64'd4;
    bb_op[2] = OP_SHL; bb_a[2] = 64'h8001; bb_b[2] = 64'h0;
    bb_op[3] = OP_NOP; bb_a[3] = 64'h1234; bb_b[3] = 64'h5678;
    @(negedge clk);
    drive(0, 1'b1, bb_op[0], bb_a[0], bb_b[0]);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i < 3) drive(0, 1'b1, bb_op[i+1], bb_a[i+1], bb_b[i+1]);
      else       drive(0, 1'b0, OP_NOP, 0, 0);
      e = model(16, bb_op[i], bb_a[i], bb_b[i]);
      chk("b2b_valid", 64'(b16.out_valid), 64'd1);
      chk("b2b_ready", 64'(b16.in_ready), 64'd1);
      chk("b2b_result", 64'(b16.ALU_OUT), e.res);
      chk("b2b_flags", 64'(o_flg(0)), 64'(e.flg));
    end

    // WIDTH=8 boundary cases
    run(1, OP_ADD, 64'd255, 64'd1);
    run(1, OP_DIV, 64'd200, 64'd7);
    run(1, OP_DIV, 64'd255, 64'd1);

    // Randomized ops on both widths
    for (int n = 0; n < 60; n++) begin
      w8 = 1'($urandom_range(0, 1));
      m  = w8 ? 64'hFF : 64'hFFFF;
      op = 4'($urandom_range(0, 15));
      a  = 64'($urandom) & m;
      b  = 64'($urandom) & m;
      if ($urandom_range(0, 5) == 0) b = 0;
      else if (op == OP_DIV && $urandom_range(0, 1) == 1) b = b & 64'hF;
      if ($urandom_range(0, 7) == 0) b = a;
      run(w8, op, a, b);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
